// File: rtl/uart_pattern_matcher_if.sv
// Bus bundle for uart_pattern_matcher: pattern configuration, input word stream and match outputs.
// The master side drives configuration and data; the slave side is the matcher itself.
interface uart_pattern_matcher_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_pat;
  logic [WIDTH-1:0] cfg_mask;
  logic             cfg_len_we;
  logic [LW-1:0]    cfg_len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             clr_cnt;
  logic             match;
  logic [LW-1:0]    idx;
  logic [15:0]      match_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_pat, cfg_mask, cfg_len_we, cfg_len,
    output in_valid, in_data, clr_cnt,
    input  match, idx, match_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_pat, cfg_mask, cfg_len_we, cfg_len,
    input  in_valid, in_data, clr_cnt,
    output match, idx, match_cnt
  );
endinterface

// File: rtl/uart_pattern_matcher.sv
// Masked multi-word sequence detector for a USART receive stream, with a registered
// one-cycle match pulse and a saturating 16-bit match counter.
module uart_pattern_matcher #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  uart_pattern_matcher_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  logic [WIDTH-1:0] pat_q  [DEPTH];
  logic [WIDTH-1:0] mask_q [DEPTH];
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    idx_q;
  logic [LW-1:0]    idx_d;
  logic [LW-1:0]    idx_inc;
  logic             match_q;
  logic             match_d;
  logic [15:0]      cnt_q;
  logic [DEPTH-1:0] slot_hit;
  logic             cur_hit;
  logic             len_ok;
  logic             cfg_any;

  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_hit[i] = ((bus.in_data ^ pat_q[i]) & ~mask_q[i]) == '0;
    end
  end

  // Loop select keeps the slot lookup width-safe when idx is wider than the slot index.
  always_comb begin
    cur_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_q == LW'(i)) cur_hit = slot_hit[i];
    end
  end

  assign len_ok  = (len_q != '0) && (len_q <= LEN_MAX);
  assign cfg_any = bus.cfg_we || bus.cfg_len_we;
  assign idx_inc = idx_q + LW'(1);

  // Progress tracking: idx is the whole HUNT/TRACK state; restart only tries slot 0.
  always_comb begin
    idx_d   = idx_q;
    match_d = 1'b0;
    if (cfg_any || !len_ok) begin
      idx_d = '0;
    end else if (bus.in_valid) begin
      if (cur_hit) begin
        if (idx_inc == len_q) begin
          idx_d   = '0;
          match_d = 1'b1;
        end else begin
          idx_d = idx_inc;
        end
      end else if ((idx_q != '0) && slot_hit[0]) begin
        idx_d = LW'(1);
      end else begin
        idx_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i]  <= '0;
        mask_q[i] <= '0;
      end
      len_q   <= LEN_MAX;
      idx_q   <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      match_q <= match_d;
      // Clear has priority over a coincident match increment.
      if (bus.clr_cnt) begin
        cnt_q <= '0;
      end else if (match_d && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.cfg_we && (bus.cfg_addr == AW'(i))) begin
          pat_q[i]  <= bus.cfg_pat;
          mask_q[i] <= bus.cfg_mask;
        end
      end
      if (bus.cfg_len_we) len_q <= bus.cfg_len;
    end
  end

  assign bus.match     = match_q;
  assign bus.idx       = idx_q;
  assign bus.match_cnt = cnt_q;
endmodule
